// File: rtl/sramwb_wr_sequencer.sv
// Write-side sequencer for a 16x4 distributed-RAM cell: buffers write requests in a 4-deep FIFO
// and drives registered WD/WAD slice pins with a single-cycle WRE framed by setup/hold cycles.
module sramwb_wr_sequencer #(
  parameter logic        INIT_CLEAR   = 1'b1,
  parameter logic [3:0]  INIT_VALUE   = 4'h0,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [3:0] WR_ADDR,
  input  logic [3:0] WR_DATA,
  output logic       A1,
  output logic       B1,
  output logic       C1,
  output logic       D1,
  output logic       A0,
  output logic       B0,
  output logic       C0,
  output logic       D0,
  output logic       WRE,
  output logic       INIT_DONE,
  output logic       BUSY
);

  localparam logic [2:0] StReset  = 3'd0;
  localparam logic [2:0] StIdle   = 3'd1;
  localparam logic [2:0] StSetup  = 3'd2;
  localparam logic [2:0] StStrobe = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;

  localparam logic [2:0] SetupLast = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] HoldLast  = 3'(HOLD_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] init_addr_q, init_addr_d;
  logic       init_done_q, init_done_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;

  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       push, pop, next_write;
  logic [3:0] head_addr, head_data;

  assign WR_READY  = init_done_q && (count_q != 3'd4);
  assign push      = WR_VALID && WR_READY;
  assign head_addr = fifo_q[rd_ptr_q][7:4];
  assign head_data = fifo_q[rd_ptr_q][3:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pop         = 1'b0;
    next_write  = 1'b0;
    unique case (state_q)
      StReset: begin
        if (INIT_CLEAR) begin
          init_addr_d = 4'd0;
          addr_d      = 4'd0;
          data_d      = INIT_VALUE;
          cnt_d       = 3'd0;
          state_d     = StSetup;
        end else begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StIdle: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          addr_d  = head_addr;
          data_d  = head_data;
          cnt_d   = 3'd0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) state_d = StStrobe;
        else                    cnt_d   = cnt_q + 3'd1;
      end
      StStrobe: begin
        if (HOLD_CYCLES == 0) begin
          next_write = 1'b1;
        end else begin
          cnt_d   = 3'd0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) next_write = 1'b1;
        else                   cnt_d      = cnt_q + 3'd1;
      end
      default: state_d = StReset;
    endcase

    // End of a write frame: chain straight into the next write so there is no idle gap.
    if (next_write) begin
      cnt_d = 3'd0;
      if (!init_done_q) begin
        if (init_addr_q == 4'hF) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          init_addr_d = init_addr_q + 4'd1;
          addr_d      = init_addr_q + 4'd1;
          data_d      = INIT_VALUE;
          state_d     = StSetup;
        end
      end else if (count_q != 3'd0) begin
        pop     = 1'b1;
        addr_d  = head_addr;
        data_d  = head_data;
        state_d = StSetup;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= StReset;
      cnt_q       <= 3'd0;
      init_addr_q <= 4'd0;
      init_done_q <= 1'b0;
      addr_q      <= 4'd0;
      data_q      <= 4'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= {WR_ADDR, WR_DATA};
  end

  assign WRE       = (state_q == StStrobe);
  assign INIT_DONE = init_done_q;
  assign BUSY      = ((state_q != StIdle) && (state_q != StReset)) || (count_q != 3'd0);

  assign C1 = data_q[0];
  assign A1 = data_q[1];
  assign D1 = data_q[2];
  assign B1 = data_q[3];
  assign D0 = addr_q[0];
  assign B0 = addr_q[1];
  assign C0 = addr_q[2];
  assign A0 = addr_q[3];

endmodule
